// File: rtl/pe_cube_result_drain.sv
// pe_cube_result_drain
// Snapshots the PE cube result vector into one of two frame buffers on a
// capture strobe and streams each frame out as fixed-width beats over a
// valid/ready handshake. Frames drain in capture order. The cube can start its
// next accumulation while the previous frame is still being drained.
module pe_cube_result_drain #(
  parameter int CUBE_NUM  = 3,
  parameter int BLOCK_NUM = 3,
  parameter int ARRAY_NUM = 3,
  parameter int OUT_BYTES = 4
) (
  input  logic                                          iClk,
  input  logic                                          iRst,
  input  logic                                          iCapture,
  input  logic [8*CUBE_NUM*BLOCK_NUM*ARRAY_NUM-1:0]     iResult,
  output logic                                          oCapReady,
  output logic [8*OUT_BYTES-1:0]                        oData,
  output logic                                          oValid,
  input  logic                                          iReady,
  output logic                                          oLast,
  output logic                                          oOverflow,
  input  logic                                          iClearErr
);

  localparam int NB    = CUBE_NUM * BLOCK_NUM * ARRAY_NUM;
  localparam int NBEAT = (NB + OUT_BYTES - 1) / OUT_BYTES;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int FW    = 8 * NB;
  localparam int DW    = 8 * OUT_BYTES;
  localparam int PW    = DW * NBEAT;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t          state_r, state_n;
  logic [FW-1:0]   buf_r [0:1];
  logic [FW-1:0]   buf_n [0:1];
  logic [1:0]      full_r, full_n;
  logic            wr_r, wr_n;
  logic            rd_r, rd_n;
  logic [BW-1:0]   beat_r, beat_n;
  logic            valid_r, valid_n;
  logic            last_r, last_n;
  logic [DW-1:0]   data_r, data_n;
  logic            ovf_r, ovf_n;
  logic            cap_ready_r, cap_ready_n;

  logic            cap_acc_s;
  logic            cap_drop_s;
  logic            hs_s;
  logic            last_hs_s;

  // Pick one beat out of a frame; bytes past the end of the frame read as zero.
  function automatic logic [DW-1:0] beat_slice(input logic [FW-1:0] frame,
                                               input logic [BW-1:0] beat);
    logic [PW-1:0] pad;
    int            base;
    pad  = PW'(frame);
    base = int'(beat) * DW;
    return pad[base +: DW];
  endfunction

  // Capture acceptance uses only registered buffer state, so a same-cycle
  // release never frees room for a capture.
  assign cap_acc_s  = iCapture & cap_ready_r;
  assign cap_drop_s = iCapture & ~cap_ready_r;
  assign hs_s       = valid_r & iReady;
  assign last_hs_s  = hs_s & (beat_r == LAST_BEAT);

  // Buffer contents and flags after this cycle's capture/release; a capture
  // always targets the buffer that is not being streamed.
  assign buf_n[0]  = (cap_acc_s && !wr_r) ? iResult : buf_r[0];
  assign buf_n[1]  = (cap_acc_s &&  wr_r) ? iResult : buf_r[1];
  assign full_n[0] = (cap_acc_s && !wr_r) ? 1'b1 :
                     (last_hs_s && !rd_r) ? 1'b0 : full_r[0];
  assign full_n[1] = (cap_acc_s &&  wr_r) ? 1'b1 :
                     (last_hs_s &&  rd_r) ? 1'b0 : full_r[1];
  assign wr_n        = cap_acc_s ? ~wr_r : wr_r;
  assign rd_n        = last_hs_s ? ~rd_r : rd_r;
  assign cap_ready_n = ~(full_n[0] & full_n[1]);
  assign ovf_n       = cap_drop_s ? 1'b1 : (iClearErr ? 1'b0 : ovf_r);

  // Drain FSM next state, beat counter and next registered output values.
  always_comb begin
    state_n = state_r;
    beat_n  = beat_r;
    valid_n = valid_r;
    case (state_r)
      ST_IDLE: begin
        if (full_n[rd_n]) begin
          state_n = ST_STREAM;
          beat_n  = '0;
          valid_n = 1'b1;
        end else begin
          state_n = ST_IDLE;
          beat_n  = '0;
          valid_n = 1'b0;
        end
      end
      ST_STREAM: begin
        if (hs_s) begin
          if (beat_r == LAST_BEAT) begin
            beat_n = '0;
            if (full_n[rd_n]) begin
              state_n = ST_STREAM;
              valid_n = 1'b1;
            end else begin
              state_n = ST_IDLE;
              valid_n = 1'b0;
            end
          end else begin
            beat_n  = beat_r + BW'(1);
            valid_n = 1'b1;
          end
        end else begin
          state_n = ST_STREAM;
          valid_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        beat_n  = '0;
        valid_n = 1'b0;
      end
    endcase
    if (valid_n) begin
      data_n = beat_slice(buf_n[rd_n], beat_n);
      last_n = (beat_n == LAST_BEAT);
    end else begin
      data_n = '0;
      last_n = 1'b0;
    end
  end

  // Control state, pointers, flags and registered outputs.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_r     <= ST_IDLE;
      full_r      <= 2'b00;
      wr_r        <= 1'b0;
      rd_r        <= 1'b0;
      beat_r      <= '0;
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      data_r      <= '0;
      ovf_r       <= 1'b0;
      cap_ready_r <= 1'b1;
    end else begin
      state_r     <= state_n;
      full_r      <= full_n;
      wr_r        <= wr_n;
      rd_r        <= rd_n;
      beat_r      <= beat_n;
      valid_r     <= valid_n;
      last_r      <= last_n;
      data_r      <= data_n;
      ovf_r       <= ovf_n;
      cap_ready_r <= cap_ready_n;
    end
  end

  // Frame storage; contents are only meaningful while the matching full flag is set.
  always_ff @(posedge iClk) begin
    buf_r[0] <= buf_n[0];
    buf_r[1] <= buf_n[1];
  end

  assign oCapReady = cap_ready_r;
  assign oData     = data_r;
  assign oValid    = valid_r;
  assign oLast     = last_r;
  assign oOverflow = ovf_r;

endmodule
